ex_stage: RTL and testbench

//  Execute stage, directly downstream of the ID/EX pipeline register; consumes its ex_* outputs.

---
 rtl/ex_stage_if.sv | 39 +++
 rtl/ex_stage.sv | 160 ++++++++++++++++
 tb/tb_ex_stage.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX operand and control bundle into the execute stage, plus the
// EX/MEM register outputs toward the memory stage and the upstream stall.
`timescale 1ns/1ps
interface ex_stage_if;
   logic        ex_flush;
   logic [31:0] ex_rdata1;
   logic [31:0] ex_rdata2;
   logic [31:0] ex_ext_imm;
   logic [4:0]  ex_sa;
   logic        ex_sa_en;
   logic [2:0]  ex_aluop;
   logic [1:0]  ex_instr_type;
   logic [1:0]  ex_cond;
   logic        ex_mem_wr;
   logic        ex_reg_wr;
   logic [4:0]  ex_waddr;
   logic        ex_stall;
   logic [31:0] mem_alu_result;
   logic [31:0] mem_wdata;
   logic        mem_mem_wr;
   logic        mem_reg_wr;
   logic [4:0]  mem_waddr;
   logic        mem_branch_taken;
   logic        mem_ovf;

   modport master (
      output ex_flush, ex_rdata1, ex_rdata2, ex_ext_imm, ex_sa, ex_sa_en, ex_aluop,
             ex_instr_type, ex_cond, ex_mem_wr, ex_reg_wr, ex_waddr,
      input  ex_stall, mem_alu_result, mem_wdata, mem_mem_wr, mem_reg_wr, mem_waddr,
             mem_branch_taken, mem_ovf
   );

   modport slave (
      input  ex_flush, ex_rdata1, ex_rdata2, ex_ext_imm, ex_sa, ex_sa_en, ex_aluop,
             ex_instr_type, ex_cond, ex_mem_wr, ex_reg_wr, ex_waddr,
      output ex_stall, mem_alu_result, mem_wdata, mem_mem_wr, mem_reg_wr, mem_waddr,
             mem_branch_taken, mem_ovf
   );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: single-cycle ALU, branch compare, iterative shift-add multiplier and the
// EX/MEM register. Define EX_OVF_TRAP_EN to trap signed ADD/SUB overflow.
`timescale 1ns/1ps
module ex_stage #(
   parameter int MUL_BITS = 1
) (
   input  logic      clk,
   input  logic      rst,
   ex_stage_if.slave ex_bus
);
   localparam int STEPS = 32 / MUL_BITS;
   localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

   typedef enum logic [2:0] {
      OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
      OP_SLL = 3'b100, OP_SRL = 3'b101, OP_SLT = 3'b110, OP_MUL = 3'b111
   } aluop_e;

   typedef enum logic {IDLE, BUSY} state_e;

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [31:0]      mul_a_q, mul_b_q, acc_q;
   logic [31:0]      result_q, wdata_q;
   logic [4:0]       waddr_q;
   logic             mem_wr_q, reg_wr_q, taken_q, ovf_q;

   logic [31:0] op_a, op_b, alu_res, acc_d;
   logic [4:0]  shamt;
   logic        taken, reg_wr_d, ovf_d, mul_start;

   assign op_a  = ex_bus.ex_rdata1;
   assign op_b  = (ex_bus.ex_instr_type == 2'b00) ? ex_bus.ex_rdata2 : ex_bus.ex_ext_imm;
   assign shamt = ex_bus.ex_sa_en ? ex_bus.ex_sa : op_a[4:0];

   // NOTE: each always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      alu_res = '0;
      case (aluop_e'(ex_bus.ex_aluop))
         OP_ADD: alu_res = op_a + op_b;
         OP_SUB: alu_res = op_a - op_b;
         OP_AND: alu_res = op_a & op_b;
         OP_OR:  alu_res = op_a | op_b;
         OP_SLL: alu_res = op_b << shamt;
         OP_SRL: alu_res = op_b >> shamt;
         OP_SLT: alu_res = {31'b0, ($signed(op_a) < $signed(op_b))};
         OP_MUL: alu_res = '0;
      endcase
   end

   always_comb begin
      taken = 1'b0;
      case (ex_bus.ex_cond)
         2'b01:   taken = (ex_bus.ex_rdata1 == ex_bus.ex_rdata2);
         2'b10:   taken = (ex_bus.ex_rdata1 != ex_bus.ex_rdata2);
         default: taken = 1'b0;
      endcase
   end

`ifdef EX_OVF_TRAP_EN
   logic ovf;
   assign ovf = ((ex_bus.ex_aluop == OP_ADD) && (op_a[31] == op_b[31]) && (alu_res[31] != op_a[31])) ||
                ((ex_bus.ex_aluop == OP_SUB) && (op_a[31] != op_b[31]) && (alu_res[31] != op_a[31]));
   assign ovf_d    = ovf;
   assign reg_wr_d = ex_bus.ex_reg_wr & ~ovf;
`else
   assign ovf_d    = 1'b0;
   assign reg_wr_d = ex_bus.ex_reg_wr;
`endif

   // Retire MUL_BITS multiplier bits per step; mul_a_q/mul_b_q are pre-shifted each edge.
   always_comb begin
      acc_d = acc_q;
      for (int k = 0; k < MUL_BITS; k++) begin
         if (mul_b_q[k]) acc_d = acc_d + (mul_a_q << k);
      end
   end

   assign mul_start = (state_q == IDLE) && (ex_bus.ex_aluop == OP_MUL) && !ex_bus.ex_flush;
   assign ex_bus.ex_stall = !rst && !ex_bus.ex_flush &&
                            (mul_start || ((state_q == BUSY) && (cnt_q != CNT_LAST)));

   // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         mul_a_q  <= '0;
         mul_b_q  <= '0;
         acc_q    <= '0;
         result_q <= '0;
         wdata_q  <= '0;
         waddr_q  <= '0;
         mem_wr_q <= 1'b0;
         reg_wr_q <= 1'b0;
         taken_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else if (ex_bus.ex_flush) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         mem_wr_q <= 1'b0;
         reg_wr_q <= 1'b0;
         taken_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (mul_start) begin
                  mul_a_q  <= op_a;
                  mul_b_q  <= op_b;
                  acc_q    <= '0;
                  cnt_q    <= '0;
                  state_q  <= BUSY;
                  mem_wr_q <= 1'b0;
                  reg_wr_q <= 1'b0;
                  taken_q  <= 1'b0;
                  ovf_q    <= 1'b0;
               end else begin
                  result_q <= alu_res;
                  wdata_q  <= ex_bus.ex_rdata2;
                  waddr_q  <= ex_bus.ex_waddr;
                  mem_wr_q <= ex_bus.ex_mem_wr;
                  reg_wr_q <= reg_wr_d;
                  taken_q  <= taken;
                  ovf_q    <= ovf_d;
               end
            end
            BUSY: begin
               acc_q   <= acc_d;
               mul_a_q <= mul_a_q << MUL_BITS;
               mul_b_q <= mul_b_q >> MUL_BITS;
               if (cnt_q == CNT_LAST) begin
                  // Upstream has held the MUL's controls throughout, so they are still valid here.
                  state_q  <= IDLE;
                  cnt_q    <= '0;
                  result_q <= acc_d;
                  wdata_q  <= ex_bus.ex_rdata2;
                  waddr_q  <= ex_bus.ex_waddr;
                  mem_wr_q <= ex_bus.ex_mem_wr;
                  reg_wr_q <= ex_bus.ex_reg_wr;
                  taken_q  <= taken;
                  ovf_q    <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ex_bus.mem_alu_result   = result_q;
   assign ex_bus.mem_wdata        = wdata_q;
   assign ex_bus.mem_mem_wr       = mem_wr_q;
   assign ex_bus.mem_reg_wr       = reg_wr_q;
   assign ex_bus.mem_waddr        = waddr_q;
   assign ex_bus.mem_branch_taken = taken_q;
   assign ex_bus.mem_ovf          = ovf_q;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: scoreboard bench for ex_stage; expected EX/MEM contents are queued when
// an instruction is driven and compared when the register is loaded.
`timescale 1ns/1ps
module tb_ex_stage;
   localparam int MUL_BITS = 1;
   localparam int STEPS    = 32 / MUL_BITS;
`ifdef EX_OVF_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR = 3'b011,
                          OP_SLL = 3'b100, OP_SRL = 3'b101, OP_SLT = 3'b110, OP_MUL = 3'b111;

   typedef struct packed {
      logic [31:0] res;
      logic [31:0] wdata;
      logic        mem_wr;
      logic        reg_wr;
      logic [4:0]  waddr;
      logic        taken;
      logic        ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   ex_stage_if bus();

   ex_stage #(.MUL_BITS(MUL_BITS)) dut (
      .clk    (clk),
      .rst    (rst),
      .ex_bus (bus)
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t exp_q[$];
   exp_t last_e;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] op, input logic [1:0] typ, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] imm, input logic [4:0] sa,
                        input logic sa_en, input logic [1:0] cond, input logic st,
                        input logic wr, input logic [4:0] wa);
      bus.ex_aluop      = op;
      bus.ex_instr_type = typ;
      bus.ex_rdata1     = a;
      bus.ex_rdata2     = b;
      bus.ex_ext_imm    = imm;
      bus.ex_sa         = sa;
      bus.ex_sa_en      = sa_en;
      bus.ex_cond       = cond;
      bus.ex_mem_wr     = st;
      bus.ex_reg_wr     = wr;
      bus.ex_waddr      = wa;
      bus.ex_flush      = 1'b0;
      #1;
   endtask

   // Reference model of the EX/MEM contents for the instruction currently driven.
   function automatic exp_t model_now();
      exp_t        e;
      logic [31:0] a, b, r;
      logic [4:0]  amt;
      int          ai, bi;
      longint      s;
      logic        v;
      a   = bus.ex_rdata1;
      b   = (bus.ex_instr_type == 2'b00) ? bus.ex_rdata2 : bus.ex_ext_imm;
      amt = bus.ex_sa_en ? bus.ex_sa : a[4:0];
      ai  = a;
      bi  = b;
      v   = 1'b0;
      r   = 32'd0;
      case (bus.ex_aluop)
         OP_ADD: begin r = a + b; s = longint'(ai) + longint'(bi); v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
         OP_SUB: begin r = a - b; s = longint'(ai) - longint'(bi); v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
         OP_AND: r = a & b;
         OP_OR:  r = a | b;
         OP_SLL: r = b << amt;
         OP_SRL: r = b >> amt;
         OP_SLT: r = (ai < bi) ? 32'd1 : 32'd0;
         default: r = a * b;
      endcase
      e.res    = r;
      e.wdata  = bus.ex_rdata2;
      e.mem_wr = bus.ex_mem_wr;
      e.waddr  = bus.ex_waddr;
      e.taken  = (bus.ex_cond == 2'b01) ? (bus.ex_rdata1 == bus.ex_rdata2) :
                 (bus.ex_cond == 2'b10) ? (bus.ex_rdata1 != bus.ex_rdata2) : 1'b0;
      e.ovf    = v & TRAP_EN;
      e.reg_wr = bus.ex_reg_wr & ~(v & TRAP_EN);
      return e;
   endfunction

   function automatic exp_t bubble();
      exp_t e;
      e        = last_e;
      e.mem_wr = 1'b0;
      e.reg_wr = 1'b0;
      e.taken  = 1'b0;
      e.ovf    = 1'b0;
      return e;
   endfunction

   task automatic push(input exp_t e);
      exp_q.push_back(e);
      last_e = e;
   endtask

   task automatic compare_out(input string tag);
      exp_t e;
      if (exp_q.size() == 0) begin
         check({tag, ".sb_empty"}, 32'd1, 32'd0);
         return;
      end
      e = exp_q.pop_front();
      check({tag, ".res"},    bus.mem_alu_result,          e.res);
      check({tag, ".wdata"},  bus.mem_wdata,               e.wdata);
      check({tag, ".mem_wr"}, 32'(bus.mem_mem_wr),         32'(e.mem_wr));
      check({tag, ".reg_wr"}, 32'(bus.mem_reg_wr),         32'(e.reg_wr));
      check({tag, ".waddr"},  32'(bus.mem_waddr),          32'(e.waddr));
      check({tag, ".taken"},  32'(bus.mem_branch_taken),   32'(e.taken));
      check({tag, ".ovf"},    32'(bus.mem_ovf),            32'(e.ovf));
   endtask

   task automatic run_op(input string tag);
      check({tag, ".stall"}, 32'(bus.ex_stall), 32'd0);
      push(model_now());
      step();
      compare_out(tag);
   endtask

   task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] prod);
      int   stall_cycles;
      int   guard;
      exp_t e;
      drive(OP_MUL, 2'b00, a, b, 32'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 5'd9);
      check({tag, ".stall_start"}, 32'(bus.ex_stall), 32'd1);
      push(bubble());
      step();
      compare_out({tag, ".bubble"});
      stall_cycles = 1;
      guard        = 0;
      while (bus.ex_stall && guard < 4 * STEPS) begin
         stall_cycles++;
         guard++;
         step();
      end
      check({tag, ".stall_cycles"}, stall_cycles, STEPS);
      e     = model_now();
      e.res = prod;
      push(e);
      step();
      compare_out(tag);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      drive(OP_ADD, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0);
      step();
      step();
      check("rst.res",    bus.mem_alu_result,          32'd0);
      check("rst.wdata",  bus.mem_wdata,               32'd0);
      check("rst.ctrl",   32'({bus.mem_mem_wr, bus.mem_reg_wr, bus.mem_branch_taken, bus.mem_ovf}), 32'd0);
      check("rst.waddr",  32'(bus.mem_waddr),          32'd0);
      check("rst.stall",  32'(bus.ex_stall),           32'd0);
      rst    = 1'b0;
      last_e = '0;

      // ADD R 5+7 into r3
      drive(OP_ADD, 2'b00, 32'd5, 32'd7, 32'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 5'd3);
      check("add.model", model_now().res, 32'd12);
      run_op("add");
      check("add.res_const", bus.mem_alu_result, 32'd12);

      // Shifts by sa field and by rdata1[4:0]
      drive(OP_SLL, 2'b00, 32'd0, 32'h0000_000F, 32'd0, 5'd4, 1'b1, 2'b00, 1'b0, 1'b1, 5'd4);
      run_op("sll_sa");
      check("sll_sa.const", bus.mem_alu_result, 32'h0000_00F0);
      drive(OP_SLL, 2'b00, 32'd8, 32'h0000_000F, 32'd0, 5'd4, 1'b0, 2'b00, 1'b0, 1'b1, 5'd4);
      run_op("sll_rs");
      check("sll_rs.const", bus.mem_alu_result, 32'h0000_0F00);
      drive(OP_SRL, 2'b01, 32'd0, 32'd0, 32'h8000_0000, 5'd31, 1'b1, 2'b00, 1'b0, 1'b1, 5'd5);
      run_op("srl_imm");
      check("srl_imm.const", bus.mem_alu_result, 32'd1);

      // SUB, AND, OR, SLT, store address via I-type, reserved type as I
      drive(OP_SUB, 2'b00, 32'd3, 32'd5, 32'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 5'd6);
      run_op("sub");
      check("sub.const", bus.mem_alu_result, 32'hFFFF_FFFE);
      drive(OP_AND, 2'b00, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 5'd7);
      run_op("and");
      drive(OP_OR, 2'b01, 32'h0000_00F0, 32'd0, 32'h0000_000F, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 5'd8);
      run_op("or_imm");
      drive(OP_SLT, 2'b00, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 5'd9);
      run_op("slt_neg");
      check("slt_neg.const", bus.mem_alu_result, 32'd1);
      drive(OP_ADD, 2'b01, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0000_0010, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0, 5'd0);
      run_op("store");
      drive(OP_ADD, 2'b11, 32'd100, 32'd999, 32'd1, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 5'd10);
      run_op("rsvd_type");
      check("rsvd_type.const", bus.mem_alu_result, 32'd101);

      // Branch conditions
      drive(OP_SUB, 2'b00, 32'h55, 32'h55, 32'd0, 5'd0, 1'b0, 2'b10, 1'b0, 1'b1, 5'd1);
      run_op("bne_eq");
      drive(OP_SUB, 2'b00, 32'h55, 32'h56, 32'd0, 5'd0, 1'b0, 2'b10, 1'b0, 1'b0, 5'd1);
      run_op("bne_ne");
      check("bne_ne.taken_const", 32'(bus.mem_branch_taken), 32'd1);
      drive(OP_SUB, 2'b00, 32'h55, 32'h55, 32'd0, 5'd0, 1'b0, 2'b01, 1'b0, 1'b0, 5'd1);
      run_op("beq_eq");
      drive(OP_SUB, 2'b00, 32'h55, 32'h55, 32'd0, 5'd0, 1'b0, 2'b11, 1'b0, 1'b0, 5'd1);
      run_op("cond_rsvd");

      // Signed overflow boundary
      drive(OP_ADD, 2'b00, 32'h7FFF_FFFF, 32'd1, 32'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 5'd11);
      run_op("add_ovf");
      check("add_ovf.res_const", bus.mem_alu_result, 32'h8000_0000);
      check("add_ovf.reg_wr_const", 32'(bus.mem_reg_wr), TRAP_EN ? 32'd0 : 32'd1);
      drive(OP_SUB, 2'b00, 32'h8000_0000, 32'd1, 32'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 5'd12);
      run_op("sub_ovf");

      // Multiplies
      run_mul("mul_spec", 32'h0001_0001, 32'h0001_0001, 32'h0002_0001);
      begin
         logic [31:0] ra, rb, rp;
         ra = $urandom;
         rb = $urandom;
         rp = ra * rb;
         run_mul("mul_rand", ra, rb, rp);
      end
      drive(OP_ADD, 2'b00, 32'd1, 32'd2, 32'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 5'd2);
      run_op("after_mul");

      // Flush in BUSY cycle 10
      drive(OP_MUL, 2'b00, 32'd3, 32'd5, 32'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 5'd13);
      push(bubble());
      step();
      compare_out("flush_busy.start");
      for (int i = 0; i < 9; i++) step();
      check("flush_busy.stall_pre", 32'(bus.ex_stall), 32'd1);
      bus.ex_flush = 1'b1;
      #1;
      check("flush_busy.stall", 32'(bus.ex_stall), 32'd0);
      push(bubble());
      step();
      compare_out("flush_busy");
      drive(OP_OR, 2'b00, 32'h1, 32'h2, 32'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 5'd14);
      run_op("flush_busy.idle");

      // Flush with a new MUL in IDLE: MUL must not start
      drive(OP_MUL, 2'b00, 32'd7, 32'd7, 32'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 5'd15);
      bus.ex_flush = 1'b1;
      #1;
      check("flush_mul.stall", 32'(bus.ex_stall), 32'd0);
      push(bubble());
      step();
      compare_out("flush_mul");
      drive(OP_SUB, 2'b00, 32'd9, 32'd4, 32'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 5'd16);
      run_op("flush_mul.idle");

      // Flush of a plain ALU op
      drive(OP_ADD, 2'b00, 32'd40, 32'd2, 32'd0, 5'd0, 1'b0, 2'b10, 1'b1, 1'b1, 5'd17);
      bus.ex_flush = 1'b1;
      #1;
      push(bubble());
      step();
      compare_out("flush_alu");

      // Random ALU ops
      for (int i = 0; i < 10; i++) begin
         drive(3'($urandom_range(0, 6)), 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
               5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
         run_op($sformatf("rand%0d", i));
      end

      // Async reset in the middle of a multiply
      drive(OP_MUL, 2'b00, 32'd11, 32'd13, 32'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 5'd18);
      push(bubble());
      step();
      compare_out("rst_mul.start");
      for (int i = 0; i < 5; i++) step();
      #2;
      rst = 1'b1;
      #1;
      check("rst_mul.res",   bus.mem_alu_result, 32'd0);
      check("rst_mul.wdata", bus.mem_wdata,      32'd0);
      check("rst_mul.ctrl",  32'({bus.mem_mem_wr, bus.mem_reg_wr, bus.mem_branch_taken, bus.mem_ovf}), 32'd0);
      check("rst_mul.waddr", 32'(bus.mem_waddr), 32'd0);
      check("rst_mul.stall", 32'(bus.ex_stall),  32'd0);
      step();
      rst    = 1'b0;
      last_e = '0;
      exp_q.delete();
      drive(OP_ADD, 2'b00, 32'd20, 32'd22, 32'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 5'd19);
      run_op("rst_mul.idle");

      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
